// File: rtl/reservation_station_aged.sv
// Aged reservation station: multi-CDB wakeup, oldest-ready select through an age matrix,
// and a registered valid/ready output stage feeding one execution unit.
module reservation_station_aged #(
  parameter int NUM_ENTRIES = 8,
  parameter int TAG_WIDTH   = 6,
  parameter int DATA_WIDTH  = 32,
  parameter int OP_WIDTH    = 4,
  parameter int NUM_CDB     = 2,
  parameter int CNT_W       = $clog2(NUM_ENTRIES + 1)
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          flush,
  input  logic                          issue_valid,
  output logic                          issue_ready,
  input  logic [OP_WIDTH-1:0]           issue_op,
  input  logic [DATA_WIDTH-1:0]         issue_val1,
  input  logic [DATA_WIDTH-1:0]         issue_val2,
  input  logic [TAG_WIDTH-1:0]          issue_tag1,
  input  logic [TAG_WIDTH-1:0]          issue_tag2,
  input  logic                          issue_rdy1,
  input  logic                          issue_rdy2,
  input  logic [TAG_WIDTH-1:0]          issue_dest_tag,
  input  logic [NUM_CDB-1:0]            cdb_valid,
  input  logic [NUM_CDB*TAG_WIDTH-1:0]  cdb_tag,
  input  logic [NUM_CDB*DATA_WIDTH-1:0] cdb_data,
  output logic                          ex_valid,
  input  logic                          ex_ready,
  output logic [OP_WIDTH-1:0]           ex_op,
  output logic [DATA_WIDTH-1:0]         ex_val1,
  output logic [DATA_WIDTH-1:0]         ex_val2,
  output logic [TAG_WIDTH-1:0]          ex_dest_tag,
  output logic [CNT_W-1:0]              occupancy,
  output logic [NUM_ENTRIES-1:0]        entry_busy,
  output logic [NUM_ENTRIES-1:0]        entry_ready
);
  localparam int IDX_W = $clog2(NUM_ENTRIES);

  logic [NUM_ENTRIES-1:0] busy_q, busy_d, rdy1_q, rdy1_d, rdy2_q, rdy2_d;
  logic [OP_WIDTH-1:0]    op_q   [NUM_ENTRIES];
  logic [OP_WIDTH-1:0]    op_d   [NUM_ENTRIES];
  logic [DATA_WIDTH-1:0]  val1_q [NUM_ENTRIES];
  logic [DATA_WIDTH-1:0]  val1_d [NUM_ENTRIES];
  logic [DATA_WIDTH-1:0]  val2_q [NUM_ENTRIES];
  logic [DATA_WIDTH-1:0]  val2_d [NUM_ENTRIES];
  logic [TAG_WIDTH-1:0]   tag1_q [NUM_ENTRIES];
  logic [TAG_WIDTH-1:0]   tag1_d [NUM_ENTRIES];
  logic [TAG_WIDTH-1:0]   tag2_q [NUM_ENTRIES];
  logic [TAG_WIDTH-1:0]   tag2_d [NUM_ENTRIES];
  logic [TAG_WIDTH-1:0]   dest_q [NUM_ENTRIES];
  logic [TAG_WIDTH-1:0]   dest_d [NUM_ENTRIES];
  // older_q[i][j] set means entry i was issued before entry j
  logic [NUM_ENTRIES-1:0] older_q [NUM_ENTRIES];
  logic [NUM_ENTRIES-1:0] older_d [NUM_ENTRIES];

  logic                  ex_valid_q, ex_valid_d;
  logic [OP_WIDTH-1:0]   ex_op_q, ex_op_d;
  logic [DATA_WIDTH-1:0] ex_val1_q, ex_val1_d, ex_val2_q, ex_val2_d;
  logic [TAG_WIDTH-1:0]  ex_dest_q, ex_dest_d;
  logic [CNT_W-1:0]      occ_q, occ_d;

  logic [IDX_W-1:0]       alloc_idx, sel_idx;
  logic                   issue_fire, sel_any, load;
  logic [NUM_ENTRIES-1:0] ready_vec, has_older;
  logic [DATA_WIDTH:0]    lk1, lk2, cap1, cap2;

  // Returns {hit, data}; the lowest-index matching port wins.
  function automatic logic [DATA_WIDTH:0] cdb_lookup(
    input logic [TAG_WIDTH-1:0]          tag,
    input logic [NUM_CDB-1:0]            vld,
    input logic [NUM_CDB*TAG_WIDTH-1:0]  tags,
    input logic [NUM_CDB*DATA_WIDTH-1:0] data
  );
    logic [DATA_WIDTH:0] res;
    res = '0;
    for (int k = NUM_CDB - 1; k >= 0; k--)
      if (vld[k] && tags[k*TAG_WIDTH +: TAG_WIDTH] == tag)
        res = {1'b1, data[k*DATA_WIDTH +: DATA_WIDTH]};
    return res;
  endfunction

  assign issue_ready = ~&busy_q;
  assign issue_fire  = issue_valid && issue_ready;
  assign ready_vec   = busy_q & rdy1_q & rdy2_q;
  assign load        = sel_any && (!ex_valid_q || ex_ready);

  always_comb begin
    alloc_idx = '0;
    for (int i = NUM_ENTRIES - 1; i >= 0; i--)
      if (!busy_q[i]) alloc_idx = IDX_W'(i);
  end

  always_comb begin
    sel_any   = 1'b0;
    sel_idx   = '0;
    has_older = '0;
    for (int i = 0; i < NUM_ENTRIES; i++) begin
      for (int j = 0; j < NUM_ENTRIES; j++)
        if (ready_vec[j] && older_q[j][i]) has_older[i] = 1'b1;
      if (ready_vec[i] && !has_older[i]) begin
        sel_any = 1'b1;
        sel_idx = IDX_W'(i);
      end
    end
  end

  always_comb begin
    busy_d  = busy_q;
    rdy1_d  = rdy1_q;
    rdy2_d  = rdy2_q;
    op_d    = op_q;
    val1_d  = val1_q;
    val2_d  = val2_q;
    tag1_d  = tag1_q;
    tag2_d  = tag2_q;
    dest_d  = dest_q;
    older_d = older_q;
    lk1     = '0;
    lk2     = '0;
    cap1    = cdb_lookup(issue_tag1, cdb_valid, cdb_tag, cdb_data);
    cap2    = cdb_lookup(issue_tag2, cdb_valid, cdb_tag, cdb_data);
    for (int i = 0; i < NUM_ENTRIES; i++) begin
      lk1 = cdb_lookup(tag1_q[i], cdb_valid, cdb_tag, cdb_data);
      lk2 = cdb_lookup(tag2_q[i], cdb_valid, cdb_tag, cdb_data);
      if (busy_q[i] && !rdy1_q[i] && lk1[DATA_WIDTH]) begin
        rdy1_d[i] = 1'b1;
        val1_d[i] = lk1[DATA_WIDTH-1:0];
      end
      if (busy_q[i] && !rdy2_q[i] && lk2[DATA_WIDTH]) begin
        rdy2_d[i] = 1'b1;
        val2_d[i] = lk2[DATA_WIDTH-1:0];
      end
    end
    if (load) busy_d[sel_idx] = 1'b0;
    if (issue_fire) begin
      busy_d[alloc_idx] = 1'b1;
      op_d[alloc_idx]   = issue_op;
      tag1_d[alloc_idx] = issue_tag1;
      tag2_d[alloc_idx] = issue_tag2;
      dest_d[alloc_idx] = issue_dest_tag;
      rdy1_d[alloc_idx] = issue_rdy1 || cap1[DATA_WIDTH];
      rdy2_d[alloc_idx] = issue_rdy2 || cap2[DATA_WIDTH];
      val1_d[alloc_idx] = (!issue_rdy1 && cap1[DATA_WIDTH]) ? cap1[DATA_WIDTH-1:0] : issue_val1;
      val2_d[alloc_idx] = (!issue_rdy2 && cap2[DATA_WIDTH]) ? cap2[DATA_WIDTH-1:0] : issue_val2;
      // New entry is younger than everything already held
      older_d[alloc_idx] = '0;
      for (int j = 0; j < NUM_ENTRIES; j++)
        if (IDX_W'(j) != alloc_idx) older_d[j][alloc_idx] = 1'b1;
    end
    if (flush) busy_d = '0;
  end

  always_comb begin
    ex_valid_d = ex_valid_q;
    ex_op_d    = ex_op_q;
    ex_val1_d  = ex_val1_q;
    ex_val2_d  = ex_val2_q;
    ex_dest_d  = ex_dest_q;
    occ_d      = occ_q + CNT_W'(issue_fire) - CNT_W'(load);
    if (load) begin
      ex_valid_d = 1'b1;
      ex_op_d    = op_q[sel_idx];
      ex_val1_d  = val1_q[sel_idx];
      ex_val2_d  = val2_q[sel_idx];
      ex_dest_d  = dest_q[sel_idx];
    end else if (ex_ready) begin
      ex_valid_d = 1'b0;
    end
    if (flush) begin
      ex_valid_d = 1'b0;
      occ_d      = '0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      busy_q     <= '0;
      rdy1_q     <= '0;
      rdy2_q     <= '0;
      ex_valid_q <= 1'b0;
      ex_op_q    <= '0;
      ex_val1_q  <= '0;
      ex_val2_q  <= '0;
      ex_dest_q  <= '0;
      occ_q      <= '0;
      for (int i = 0; i < NUM_ENTRIES; i++) begin
        op_q[i]    <= '0;
        val1_q[i]  <= '0;
        val2_q[i]  <= '0;
        tag1_q[i]  <= '0;
        tag2_q[i]  <= '0;
        dest_q[i]  <= '0;
        older_q[i] <= '0;
      end
    end else begin
      busy_q     <= busy_d;
      rdy1_q     <= rdy1_d;
      rdy2_q     <= rdy2_d;
      ex_valid_q <= ex_valid_d;
      ex_op_q    <= ex_op_d;
      ex_val1_q  <= ex_val1_d;
      ex_val2_q  <= ex_val2_d;
      ex_dest_q  <= ex_dest_d;
      occ_q      <= occ_d;
      for (int i = 0; i < NUM_ENTRIES; i++) begin
        op_q[i]    <= op_d[i];
        val1_q[i]  <= val1_d[i];
        val2_q[i]  <= val2_d[i];
        tag1_q[i]  <= tag1_d[i];
        tag2_q[i]  <= tag2_d[i];
        dest_q[i]  <= dest_d[i];
        older_q[i] <= older_d[i];
      end
    end
  end

  assign ex_valid    = ex_valid_q;
  assign ex_op       = ex_op_q;
  assign ex_val1     = ex_val1_q;
  assign ex_val2     = ex_val2_q;
  assign ex_dest_tag = ex_dest_q;
  assign occupancy   = occ_q;
  assign entry_busy  = busy_q;
  assign entry_ready = ready_vec;

endmodule

// File: tb/tb_reservation_station_aged.sv
// Bench for reservation_station_aged: issue-ordered list model, scoreboard of expected
// dispatches popped by an independent monitor on every ex handshake.
module tb_reservation_station_aged;
  localparam int N  = 8;
  localparam int TW = 6;
  localparam int DW = 32;
  localparam int OW = 4;
  localparam int NC = 2;
  localparam int CW = $clog2(N + 1);

  logic          clk = 1'b0;
  logic          rst, flush, issue_valid, issue_ready;
  logic [OW-1:0] issue_op;
  logic [DW-1:0] issue_val1, issue_val2;
  logic [TW-1:0] issue_tag1, issue_tag2, issue_dest_tag;
  logic          issue_rdy1, issue_rdy2;
  logic [NC-1:0] cdb_valid;
  logic [NC*TW-1:0] cdb_tag;
  logic [NC*DW-1:0] cdb_data;
  logic          ex_valid, ex_ready;
  logic [OW-1:0] ex_op;
  logic [DW-1:0] ex_val1, ex_val2;
  logic [TW-1:0] ex_dest_tag;
  logic [CW-1:0] occupancy;
  logic [N-1:0]  entry_busy, entry_ready;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  reservation_station_aged #(.NUM_ENTRIES(N), .TAG_WIDTH(TW), .DATA_WIDTH(DW),
                             .OP_WIDTH(OW), .NUM_CDB(NC)) dut (
    .clk(clk), .rst(rst), .flush(flush),
    .issue_valid(issue_valid), .issue_ready(issue_ready), .issue_op(issue_op),
    .issue_val1(issue_val1), .issue_val2(issue_val2),
    .issue_tag1(issue_tag1), .issue_tag2(issue_tag2),
    .issue_rdy1(issue_rdy1), .issue_rdy2(issue_rdy2), .issue_dest_tag(issue_dest_tag),
    .cdb_valid(cdb_valid), .cdb_tag(cdb_tag), .cdb_data(cdb_data),
    .ex_valid(ex_valid), .ex_ready(ex_ready), .ex_op(ex_op),
    .ex_val1(ex_val1), .ex_val2(ex_val2), .ex_dest_tag(ex_dest_tag),
    .occupancy(occupancy), .entry_busy(entry_busy), .entry_ready(entry_ready)
  );

  typedef struct {
    logic [OW-1:0] op;
    logic [DW-1:0] v1, v2;
    logic [TW-1:0] t1, t2, dest;
    bit            r1, r2;
    int            idx;
  } ent_t;

  typedef struct {
    logic [OW-1:0] op;
    logic [DW-1:0] v1, v2;
    logic [TW-1:0] dest;
  } exp_t;

  ent_t mq[$];   // held instructions, oldest first
  exp_t sbq[$];  // dispatches in output-stage order
  bit   m_exv;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic void cdb_match(input logic [TW-1:0] t, output bit hit, output logic [DW-1:0] d);
    hit = 0;
    d   = '0;
    for (int k = 0; k < NC; k++)
      if (!hit && cdb_valid[k] && cdb_tag[k*TW +: TW] == t) begin
        hit = 1;
        d   = cdb_data[k*DW +: DW];
      end
  endfunction

  // Advance the model over the coming clock edge using the inputs currently driven.
  task automatic model_step();
    int            sel, n_before, free_i;
    bit [N-1:0]    used;
    bit            hit;
    logic [DW-1:0] d;
    ent_t          e;
    exp_t          x;
    if (flush) begin
      mq.delete();
      sbq.delete();
      m_exv = 0;
      return;
    end
    n_before = mq.size();
    used = '0;
    foreach (mq[i]) used[mq[i].idx] = 1;
    if (m_exv && ex_ready) m_exv = 0;
    if (!m_exv) begin
      sel = -1;
      foreach (mq[i]) if (sel < 0 && mq[i].r1 && mq[i].r2) sel = i;
      if (sel >= 0) begin
        x.op = mq[sel].op; x.v1 = mq[sel].v1; x.v2 = mq[sel].v2; x.dest = mq[sel].dest;
        sbq.push_back(x);
        mq.delete(sel);
        m_exv = 1;
      end
    end
    foreach (mq[i]) begin
      e = mq[i];
      if (!e.r1) begin cdb_match(e.t1, hit, d); if (hit) begin e.r1 = 1; e.v1 = d; end end
      if (!e.r2) begin cdb_match(e.t2, hit, d); if (hit) begin e.r2 = 1; e.v2 = d; end end
      mq[i] = e;
    end
    if (issue_valid && n_before < N) begin
      free_i = -1;
      for (int i = N - 1; i >= 0; i--) if (!used[i]) free_i = i;
      e.op = issue_op; e.dest = issue_dest_tag; e.idx = free_i;
      e.t1 = issue_tag1; e.t2 = issue_tag2;
      e.r1 = issue_rdy1; e.r2 = issue_rdy2;
      e.v1 = issue_val1; e.v2 = issue_val2;
      if (!e.r1) begin cdb_match(e.t1, hit, d); if (hit) begin e.r1 = 1; e.v1 = d; end end
      if (!e.r2) begin cdb_match(e.t2, hit, d); if (hit) begin e.r2 = 1; e.v2 = d; end end
      mq.push_back(e);
    end
  endtask

  task automatic check_state();
    logic [N-1:0] bm, rm;
    bm = '0;
    rm = '0;
    foreach (mq[i]) begin
      bm[mq[i].idx] = 1'b1;
      if (mq[i].r1 && mq[i].r2) rm[mq[i].idx] = 1'b1;
    end
    chk("ex_valid", ex_valid, m_exv);
    chk("occupancy", occupancy, mq.size());
    chk("issue_ready", issue_ready, mq.size() < N);
    chk("entry_busy", entry_busy, bm);
    chk("entry_ready", entry_ready, rm);
  endtask

  task automatic step();
    model_step();
    @(posedge clk);
    #1;
    check_state();
  endtask

  task automatic idle();
    issue_valid = 0; issue_op = '0; issue_val1 = '0; issue_val2 = '0;
    issue_tag1 = '0; issue_tag2 = '0; issue_rdy1 = 0; issue_rdy2 = 0; issue_dest_tag = '0;
    cdb_valid = '0; cdb_tag = '0; cdb_data = '0; flush = 0; ex_ready = 1;
  endtask

  task automatic issue(input int op, input int v1, input int v2, input int t1, input int t2,
                       input bit r1, input bit r2, input int dest);
    issue_valid = 1; issue_op = OW'(op); issue_val1 = DW'(v1); issue_val2 = DW'(v2);
    issue_tag1 = TW'(t1); issue_tag2 = TW'(t2); issue_rdy1 = r1; issue_rdy2 = r2;
    issue_dest_tag = TW'(dest);
  endtask

  task automatic cdb(input int port, input int tag, input logic [DW-1:0] data);
    cdb_valid[port] = 1'b1;
    cdb_tag[port*TW +: TW] = TW'(tag);
    cdb_data[port*DW +: DW] = data;
  endtask

  // Monitor: every handshake on the output stage retires the oldest expected dispatch.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (!rst && !flush && ex_valid && ex_ready) begin
        if (sbq.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL ex_unexpected: got dest %0h expected no dispatch at %0t", ex_dest_tag, $time);
        end else begin
          e = sbq.pop_front();
          chk("ex_op", ex_op, e.op);
          chk("ex_val1", ex_val1, e.v1);
          chk("ex_val2", ex_val2, e.v2);
          chk("ex_dest_tag", ex_dest_tag, e.dest);
        end
      end
    end
  end

  initial begin
    int pr;
    rst = 1;
    idle();
    m_exv = 0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_ex_valid", ex_valid, 0);
    chk("rst_ex_fields", {ex_op, ex_val1, ex_val2, ex_dest_tag}, 0);
    chk("rst_occupancy", occupancy, 0);
    chk("rst_issue_ready", issue_ready, 1);
    chk("rst_entry_busy", entry_busy, 0);
    rst = 0;

    // Single ready instruction: in the output stage two edges after issue
    idle(); issue(3, 5, 7, 0, 0, 1, 1, 1); step();
    idle(); step();
    chk("t1_ex_valid", ex_valid, 1);
    chk("t1_ex_val1", ex_val1, 5);
    chk("t1_ex_val2", ex_val2, 7);
    chk("t1_occupancy", occupancy, 0);
    idle(); step();

    // A waits on tag 10, younger ready B overtakes, then port1 wakes A
    idle(); issue(1, 0, 2, 10, 0, 0, 1, 2); step();
    idle(); issue(2, 3, 4, 0, 0, 1, 1, 3); step();
    idle(); step();
    idle(); step();
    idle(); cdb(1, 10, 32'hAA); step();
    chk("t2_not_early", ex_valid, 0);
    idle(); step();
    chk("t2_ex_val1", ex_val1, 32'hAA);
    idle(); step();

    // Same-cycle capture at issue time
    idle(); issue(4, 0, 9, 12, 0, 0, 1, 4); cdb(0, 12, 32'h55); step();
    chk("t3_entry_ready", |entry_ready, 1);
    repeat (3) begin idle(); step(); end

    // Fill all entries on tag 20, then drain in issue order
    for (int i = 0; i < N; i++) begin idle(); ex_ready = 0; issue(i, i, 100 + i, 20, 0, 0, 1, 16 + i); step(); end
    chk("t4_full_ready", issue_ready, 0);
    chk("t4_full_occ", occupancy, N);
    idle(); ex_ready = 0; issue(9, 9, 9, 0, 0, 1, 1, 40); step();
    idle(); ex_ready = 0; cdb(0, 20, 32'h1234); step();
    repeat (N + 3) begin idle(); step(); end

    // Stall with three ready entries
    for (int i = 0; i < 3; i++) begin idle(); ex_ready = 0; issue(5, 50 + i, 60 + i, 0, 0, 1, 1, 48 + i); step(); end
    repeat (6) begin idle(); ex_ready = 0; step(); end
    chk("t5_stall_occ", occupancy, 2);
    repeat (5) begin idle(); step(); end

    // Flush with busy entries, a held output and a simultaneous issue
    for (int i = 0; i < 6; i++) begin idle(); ex_ready = 0; issue(6, i, i, 0, 0, 1, 1, 56 + i); step(); end
    idle(); ex_ready = 0; flush = 1; issue(7, 1, 1, 0, 0, 1, 1, 63); step();
    chk("t6_flush_occ", occupancy, 0);
    chk("t6_flush_exv", ex_valid, 0);
    chk("t6_flush_busy", entry_busy, 0);

    // Randomized traffic with one asynchronous reset in the middle
    pr = 60;
    for (int c = 0; c < 1600; c++) begin
      if (c % 100 == 0) pr = (c / 100 % 3 == 0) ? 20 : ((c / 100 % 3 == 1) ? 60 : 95);
      if (c == 800) begin
        rst = 1;
        #2;
        chk("async_rst_exv", ex_valid, 0);
        chk("async_rst_occ", occupancy, 0);
        chk("async_rst_busy", entry_busy, 0);
        mq.delete(); sbq.delete(); m_exv = 0;
        idle();
        @(posedge clk);
        #1;
        rst = 0;
      end
      issue_valid = ($urandom_range(0, 99) < 60);
      issue_op = OW'($urandom_range(0, 15));
      issue_val1 = $urandom; issue_val2 = $urandom;
      issue_tag1 = TW'($urandom_range(0, 7)); issue_tag2 = TW'($urandom_range(0, 7));
      issue_rdy1 = ($urandom_range(0, 1) == 1); issue_rdy2 = ($urandom_range(0, 1) == 1);
      issue_dest_tag = TW'($urandom_range(0, 63));
      for (int k = 0; k < NC; k++) begin
        cdb_valid[k] = ($urandom_range(0, 99) < 30);
        cdb_tag[k*TW +: TW] = TW'($urandom_range(0, 7));
        cdb_data[k*DW +: DW] = $urandom;
      end
      ex_ready = ($urandom_range(0, 99) < pr);
      flush = ($urandom_range(0, 99) < 2);
      step();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
